// File: rtl/systolic_drain_if.sv
// Handshake bundle between a systolic column's last slice, the drain
// accumulator, and the downstream result consumer.
interface systolic_drain_if #(
  parameter int WIDTH  = 8,
  parameter int ACCW   = 24,
  parameter int PASSES = 4
);
  logic signed [2*WIDTH-1:0]        y_in;
  logic                             y_valid;
  logic                             y_ready;
  logic                             clear;
  logic signed [ACCW-1:0]           out_data;
  logic                             out_valid;
  logic                             out_ready;
  logic [$clog2(PASSES+1)-1:0]      pass_cnt;

  modport master (
    output y_in, y_valid, clear, out_ready,
    input  y_ready, out_data, out_valid, pass_cnt
  );

  modport slave (
    input  y_in, y_valid, clear, out_ready,
    output y_ready, out_data, out_valid, pass_cnt
  );
endinterface

// File: rtl/systolic_drain.sv
// Accumulates PASSES partial sums from a systolic column into one wide result
// and queues finished results in a small FIFO for the consumer.
module systolic_drain #(
  parameter int WIDTH  = 8,
  parameter int ACCW   = 24,
  parameter int PASSES = 4,
  parameter int DEPTH  = 4
) (
  input logic             clk,
  input logic             rst,
  systolic_drain_if.slave bus
);
  localparam int CW = $clog2(PASSES+1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST_PASS  = CW'(PASSES-1);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                 state;
  logic [CW-1:0]          pass_cnt;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            count;
  logic signed [ACCW-1:0] y_ext;
  logic signed [ACCW-1:0] sum;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   accept;
  logic                   last;
  logic                   push;
  logic                   pop;

  assign fifo_full  = (count == FULL_COUNT);
  assign fifo_empty = (count == '0);

  // In IDLE the stale accumulator is ignored, so the first beat loads rather than adds.
  assign y_ext  = ACCW'(bus.y_in);
  assign sum    = (state == IDLE) ? y_ext : acc + y_ext;
  assign accept = bus.y_valid && !fifo_full && !bus.clear;
  assign last   = (pass_cnt == LAST_PASS);
  assign push   = accept && last;
  assign pop    = !fifo_empty && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pass_cnt <= '0;
      acc      <= '0;
    end else if (bus.clear) begin
      state    <= IDLE;
      pass_cnt <= '0;
    end else if (accept) begin
      acc <= sum;
      if (last) begin
        state    <= IDLE;
        pass_cnt <= '0;
      end else begin
        state    <= ACCUM;
        pass_cnt <= pass_cnt + CW'(1);
      end
    end
  end

  // Storage needs no reset: out_data is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.y_ready   = !fifo_full;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_empty ? '0 : mem[rd_ptr];
  assign bus.pass_cnt  = pass_cnt;
endmodule

// File: tb/tb_systolic_drain.sv
// Scoreboard bench for systolic_drain: expected results are queued as beats
// are driven and checked as the consumer pops them.
module tb_systolic_drain;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic signed [23:0] exp_q [$];
  logic signed [23:0] exp_v;

  systolic_drain_if #(.WIDTH(8), .ACCW(24), .PASSES(4)) dif ();
  systolic_drain_if #(.WIDTH(8), .ACCW(16), .PASSES(4)) wif ();

  systolic_drain #(.WIDTH(8), .ACCW(24), .PASSES(4), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  systolic_drain #(.WIDTH(8), .ACCW(16), .PASSES(4), .DEPTH(4)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (wif)
  );

  always #5 clk = ~clk;

  // Handshake inputs only change just after posedge, so the negedge view is the next pop.
  always @(negedge clk) begin
    if (rst === 1'b0 && dif.out_valid === 1'b1 && dif.out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL scoreboard_unexpected got %0d expected no output", dif.out_data);
      end else begin
        exp_v = exp_q.pop_front();
        if (dif.out_data !== exp_v) begin
          errors++;
          $display("[TB] FAIL scoreboard_data got %0d expected %0d", dif.out_data, exp_v);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic send_beat(input logic signed [15:0] v);
    int n = 0;
    dif.y_valid = 1'b1;
    dif.y_in    = v;
    @(negedge clk);
    while (dif.y_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("[TB] FAIL beat_timeout got y_ready=%b expected 1", dif.y_ready);
    end
    @(posedge clk);
    #1;
    dif.y_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    dif.y_valid   = 1'b0;
    dif.y_in      = '0;
    dif.clear     = 1'b0;
    dif.out_ready = 1'b0;
    wif.y_valid   = 1'b0;
    wif.y_in      = '0;
    wif.clear     = 1'b0;
    wif.out_ready = 1'b0;
    #2;
    checks++;
    if (dif.y_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_y_ready got %b expected 1", dif.y_ready); end
    checks++;
    if (dif.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b expected 0", dif.out_valid); end
    checks++;
    if (dif.out_data !== 24'sd0) begin errors++; $display("[TB] FAIL reset_out_data got %0d expected 0", dif.out_data); end
    checks++;
    if (dif.pass_cnt !== 3'd0) begin errors++; $display("[TB] FAIL reset_pass_cnt got %0d expected 0", dif.pass_cnt); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    dif.out_ready = 1'b1;
    send_beat(16'sd10);
    send_beat(-16'sd3);
    checks++;
    if (dif.pass_cnt !== 3'd2) begin errors++; $display("[TB] FAIL basic_pass_cnt got %0d expected 2", dif.pass_cnt); end
    send_beat(16'sd7);
    exp_q.push_back(24'sd114);
    send_beat(16'sd100);
    checks++;
    if (dif.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_out_valid got %b expected 1", dif.out_valid); end
    checks++;
    if (dif.out_data !== 24'sd114) begin errors++; $display("[TB] FAIL basic_out_data got %0d expected 114", dif.out_data); end
    checks++;
    if (dif.pass_cnt !== 3'd0) begin errors++; $display("[TB] FAIL basic_pass_wrap got %0d expected 0", dif.pass_cnt); end
    @(posedge clk);
    #1;
    checks++;
    if (dif.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_one_cycle got %b expected 0", dif.out_valid); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL basic_queue got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_full();
    dif.out_ready = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int b = 0; b < 4; b++) begin
        if (b == 3) exp_q.push_back(-24'sd131072);
        send_beat(16'sh8000);
      end
    end
    checks++;
    if (dif.y_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_y_ready got %b expected 0", dif.y_ready); end
    checks++;
    if (dif.out_data !== -24'sd131072) begin errors++; $display("[TB] FAIL full_head got %0d expected -131072", dif.out_data); end
    dif.y_valid = 1'b1;
    dif.y_in    = 16'sd5;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    dif.y_valid = 1'b0;
    checks++;
    if (dif.pass_cnt !== 3'd0) begin errors++; $display("[TB] FAIL full_stall_pass got %0d expected 0", dif.pass_cnt); end
    checks++;
    if (dif.out_data !== -24'sd131072) begin errors++; $display("[TB] FAIL full_stable got %0d expected -131072", dif.out_data); end
    dif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (dif.y_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_unstall got %b expected 1", dif.y_ready); end
    drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL full_queue got %0d expected 0", exp_q.size()); end
    checks++;
    if (dif.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_empty got %b expected 0", dif.out_valid); end
    dif.out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    wif.out_ready = 1'b0;
    wif.y_valid   = 1'b1;
    wif.y_in      = 16'sh7FFF;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    wif.y_valid = 1'b0;
    checks++;
    if (wif.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL wrap_out_valid got %b expected 1", wif.out_valid); end
    checks++;
    if (wif.out_data !== 16'hFFFC) begin errors++; $display("[TB] FAIL wrap_out_data got %h expected fffc", wif.out_data); end
    checks++;
    if (wif.pass_cnt !== 3'd0) begin errors++; $display("[TB] FAIL wrap_pass_cnt got %0d expected 0", wif.pass_cnt); end
    wif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    wif.out_ready = 1'b0;
    checks++;
    if (wif.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL wrap_pop got %b expected 0", wif.out_valid); end
  endtask

  task automatic test_clear();
    dif.out_ready = 1'b1;
    send_beat(16'sd5);
    send_beat(16'sd5);
    checks++;
    if (dif.pass_cnt !== 3'd2) begin errors++; $display("[TB] FAIL clear_pre_pass got %0d expected 2", dif.pass_cnt); end
    dif.y_valid = 1'b1;
    dif.y_in    = 16'sd9;
    dif.clear   = 1'b1;
    @(posedge clk);
    #1;
    dif.clear   = 1'b0;
    dif.y_valid = 1'b0;
    checks++;
    if (dif.pass_cnt !== 3'd0) begin errors++; $display("[TB] FAIL clear_pass_cnt got %0d expected 0", dif.pass_cnt); end
    exp_q.push_back(24'sd10);
    send_beat(16'sd1);
    send_beat(16'sd2);
    send_beat(16'sd3);
    send_beat(16'sd4);
    drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL clear_queue got %0d expected 0", exp_q.size()); end
    dif.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    dif.out_ready = 1'b0;
    exp_q.push_back(24'sd4);
    repeat (4) send_beat(16'sd1);
    exp_q.push_back(24'sd8);
    repeat (4) send_beat(16'sd2);
    exp_q.push_back(24'sd12);
    repeat (3) send_beat(16'sd3);
    dif.y_valid   = 1'b1;
    dif.y_in      = 16'sd3;
    dif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    dif.y_valid   = 1'b0;
    dif.out_ready = 1'b0;
    checks++;
    if (dif.out_data !== 24'sd8) begin errors++; $display("[TB] FAIL b2b_head got %0d expected 8", dif.out_data); end
    checks++;
    if (dif.y_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_y_ready got %b expected 1", dif.y_ready); end
    dif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (dif.out_valid !== 1'b1 || dif.out_data !== 24'sd12) begin
      errors++;
      $display("[TB] FAIL b2b_second got valid=%b data=%0d expected valid=1 data=12", dif.out_valid, dif.out_data);
    end
    @(posedge clk);
    #1;
    dif.out_ready = 1'b0;
    checks++;
    if (dif.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_occupancy got %b expected 0", dif.out_valid); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL b2b_queue got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    dif.out_ready = 1'b0;
    repeat (4) send_beat(16'sd2);
    send_beat(16'sd1);
    send_beat(16'sd1);
    checks++;
    if (dif.pass_cnt !== 3'd2 || dif.out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rmid_pre got pass=%0d valid=%b expected pass=2 valid=1", dif.pass_cnt, dif.out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (dif.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_out_valid got %b expected 0", dif.out_valid); end
    checks++;
    if (dif.pass_cnt !== 3'd0) begin errors++; $display("[TB] FAIL rmid_pass_cnt got %0d expected 0", dif.pass_cnt); end
    checks++;
    if (dif.out_data !== 24'sd0) begin errors++; $display("[TB] FAIL rmid_out_data got %0d expected 0", dif.out_data); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    dif.out_ready = 1'b1;
    exp_q.push_back(24'sd4);
    repeat (4) send_beat(16'sd1);
    drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL rmid_queue got %0d expected 0", exp_q.size()); end
    checks++;
    if (dif.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_empty got %b expected 0", dif.out_valid); end
    dif.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_clear();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/systolic_drain.md
SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

Interface
REQ-001 SHALL have parameter WIDTH, default 8: slice operand width; partial sums are 2*WIDTH bits.
REQ-002 SHALL have parameter ACCW, default 24: accumulator and output width, ACCW >= 2*WIDTH.
REQ-003 SHALL have parameter PASSES, default 4: number of partial sums per result, PASSES >= 1.
REQ-004 SHALL have parameter DEPTH, default 4: output FIFO entries, a power of 2 and >= 2.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port y_in, input, signed 2*WIDTH bits: partial sum from the last slice of a systolic column.
REQ-008 SHALL have port y_valid, input, 1 bit: y_in carries a valid partial sum this cycle.
REQ-009 SHALL have port y_ready, output, 1 bit: drain can accept y_in this cycle.
REQ-010 SHALL have port clear, input, 1 bit: synchronous abort of the accumulation in progress.
REQ-011 SHALL have port out_data, output, signed ACCW bits: head-of-FIFO result.
REQ-012 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: consumer accepts out_data.
REQ-014 SHALL have port pass_cnt, output, $clog2(PASSES+1) bits: partial sums absorbed into the current accumulation.

Function
REQ-015 SHALL accept a beat when y_valid && y_ready at posedge clk; unaccepted beats SHALL have no effect.
REQ-016 SHALL sign-extend y_in to ACCW bits and add it to the accumulator in two's complement, wrapping modulo 2^ACCW with no saturation and no flag.
REQ-017 SHALL use a two-state FSM: IDLE (pass_cnt==0, accumulator ignored) and ACCUM (0 < pass_cnt < PASSES).
REQ-018 In IDLE, an accepted beat SHALL load the accumulator with sext(y_in), not add to it; pass_cnt SHALL become 1 and the FSM SHALL go to ACCUM, unless PASSES==1.
REQ-019 In ACCUM, an accepted beat SHALL add to the accumulator and increment pass_cnt.
REQ-020 The beat that completes PASSES beats SHALL push accumulator+sext(y_in) into the FIFO, reset pass_cnt to 0 and return the FSM to IDLE, all at the same edge.
REQ-021 y_ready SHALL equal !fifo_full, decoded from registered state with no combinational path from y_valid or out_ready; a full FIFO stalls every beat, not only the completing one.
REQ-022 out_valid SHALL equal !fifo_empty; the head entry SHALL pop at a posedge where out_valid && out_ready.
REQ-023 Latency: a result pushed at edge N into an empty FIFO SHALL present out_valid=1 and the correct out_data from edge N until popped; out_data SHALL stay stable while out_valid && !out_ready.
REQ-024 Push and pop at the same edge SHALL leave the occupancy unchanged and keep FIFO order; pointers SHALL wrap modulo DEPTH.
REQ-025 A pop of the last entry SHALL drive out_valid low after that edge; a pop from a full FIFO SHALL drive y_ready high after that edge.
REQ-026 clear=1 at an edge SHALL force pass_cnt to 0 and the FSM to IDLE; a beat offered in the same cycle SHALL be discarded; FIFO contents and the pop path SHALL be unaffected.
REQ-027 out_data SHALL be 0 when the FIFO is empty.

Reset
REQ-028 rst=1 SHALL asynchronously force the FSM to IDLE, pass_cnt=0, accumulator=0, FIFO empty, out_valid=0, out_data=0 and y_ready=1.
REQ-029 rst asserted mid-accumulation or with the FIFO non-empty SHALL discard all partial and queued results; after rst deasserts, the first accepted beat SHALL start a fresh result.

Verification (WIDTH=8, ACCW=24, PASSES=4, DEPTH=4)
REQ-030 Beats 10, -3, 7, 100 with out_ready=1 -> a single result of 114; out_valid high for exactly one cycle after the 4th beat.
REQ-031 Four results of 4x(-32768) each with out_ready=0 -> each result is -131072, y_ready=0 once the 4th result is pushed, a 17th beat stalls, and after popping the results come out in order and y_ready returns to 1.
REQ-032 Accumulator fed 0x7FFF per beat with ACCW=16 -> wrapped result 0xFFFC (-4).
REQ-033 Beats 5, 5, then clear together with a beat of 9, then 1, 2, 3, 4 -> the only result is 10.
REQ-034 FIFO at 2 entries, result push and pop at the same edge -> occupancy stays 2 and order is preserved.
REQ-035 rst pulse after 2 beats with 1 result queued -> out_valid=0 and pass_cnt=0 immediately; beats 1, 1, 1, 1 afterwards -> result 4.
